// File: rtl/fpga_spi_regs.sv
// SPI responder (mode 0, 32-bit LMS7-style frames) fronting a bank of 16-bit
// configuration registers. SPI pins are oversampled in the clk_clk domain.
module fpga_spi_regs #(
  parameter int          ADDR_W    = 5,
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter logic [15:0] RST_VAL   = 16'h0000
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        spi_sclk,
  input  logic                        spi_mosi,
  input  logic                        spi_ss_n,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  output logic [16*(2**ADDR_W)-1:0]   regs_out,
  output logic                        wr_strobe,
  output logic [ADDR_W-1:0]           wr_addr
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_q, sclk_d, mosi_q, mosi_d, ss_q, ss_d;
  logic [1:0]              vld_q, vld_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [31:0]             sr_q, sr_d;
  logic [15:0]             so_q, so_d;
  logic                    rd_ld_q, rd_ld_d, wr_go_q, wr_go_d, fall_go_q, fall_go_d;
  logic                    miso_q, miso_d, oe_q, oe_d, wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [NREG-1:0][15:0]   regs_q, regs_d;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [14:0]             addr_rd, addr_wr;

  function automatic logic hit(input logic [14:0] a);
    return a[14:ADDR_W] == BASE_ADDR[14:ADDR_W];
  endfunction

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  // Address sits in the low half after 16 bits, in the high half after 32.
  assign addr_rd   = sr_q[14:0];
  assign addr_wr   = sr_q[30:16];

  always_comb begin
    sclk_d      = {sclk_q[1:0], spi_sclk};
    mosi_d      = {mosi_q[1:0], spi_mosi};
    ss_d        = {ss_q[1:0], spi_ss_n};
    vld_d       = {vld_q[0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    so_d        = so_q;
    rd_ld_d     = 1'b0;
    wr_go_d     = 1'b0;
    fall_go_d   = 1'b0;
    miso_d      = miso_q;
    oe_d        = vld_q[1] & ~ss_q[1];
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    // Actions detected last cycle take effect now (one cycle after detect).
    if (fall_go_q) begin
      miso_d = so_q[15];
      so_d   = {so_q[14:0], 1'b0};
    end
    if (rd_ld_q && !sr_q[15])
      so_d = hit(addr_rd) ? regs_q[addr_rd[ADDR_W-1:0]] : 16'h0000;
    if (wr_go_q && sr_q[31] && hit(addr_wr)) begin
      regs_d[addr_wr[ADDR_W-1:0]] = sr_q[15:0];
      wr_strobe_d                 = 1'b1;
      wr_addr_d                   = addr_wr[ADDR_W-1:0];
    end

    case (state_q)
      SHIFT: if (sclk_rise) begin
        sr_d  = {sr_q[30:0], mosi_q[1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd15) rd_ld_d = 1'b1;
        if (cnt_q == 6'd31) begin
          wr_go_d = 1'b1;
          state_d = DONE;
        end
      end
      default: ;
    endcase

    // so_q is empty for write frames and after bit 0, so late falls drive 0.
    if (state_q != IDLE && sclk_fall && cnt_q >= 6'd16) fall_go_d = 1'b1;

    if (ss_fall) begin
      state_d = SHIFT;
      cnt_d   = 6'd0;
      sr_d    = 32'h0;
      so_d    = 16'h0;
      miso_d  = 1'b0;
    end
    if (ss_rise) begin
      state_d   = IDLE;
      cnt_d     = 6'd0;
      so_d      = 16'h0;
      miso_d    = 1'b0;
      rd_ld_d   = 1'b0;
      wr_go_d   = 1'b0;
      fall_go_d = 1'b0;
    end
  end

  // ss sync resets low so a select held across reset never looks like a fall.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      sclk_q      <= '0;
      mosi_q      <= '0;
      ss_q        <= '0;
      vld_q       <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      so_q        <= '0;
      rd_ld_q     <= 1'b0;
      wr_go_q     <= 1'b0;
      fall_go_q   <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      regs_q      <= {NREG{RST_VAL}};
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      so_q        <= so_d;
      rd_ld_q     <= rd_ld_d;
      wr_go_q     <= wr_go_d;
      fall_go_q   <= fall_go_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign regs_out    = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
endmodule

// File: tb/tb_fpga_spi_regs.sv
// Bench for fpga_spi_regs: directed frames plus random frames against a
// register-array model of the frame protocol; SCLK runs at clk/8.
module tb_fpga_spi_regs;
  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic          spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
  logic          spi_miso, spi_miso_oe, wr_strobe;
  logic [511:0]  regs_out;
  logic [4:0]    wr_addr;

  fpga_spi_regs dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe), .regs_out(regs_out), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr)
  );

  always #5 clk_clk = ~clk_clk;

  int         n_vec = 0, n_err = 0, n_strobe = 0;
  logic [15:0] m [32];
  logic [4:0]  exp_wa = '0;
  logic        oe_mid;

  always @(negedge clk_clk) if (wr_strobe) n_strobe++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Send one frame; optionally stop after nbits, add extra clocks, or pulse reset.
  task automatic xfer(input logic [31:0] fr, input int nbits, input int extra,
                      input int rst_bit, output logic [15:0] rd, output logic stray);
    rd = '0; stray = 1'b0;
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk_clk);
    for (int i = 0; i < nbits + extra; i++) begin
      spi_mosi = (i < 32) ? fr[31-i] : 1'b0;
      if (i == rst_bit) begin
        reset_reset = 1'b1;
        repeat (4) @(negedge clk_clk);
        reset_reset = 1'b0;
      end else repeat (4) @(negedge clk_clk);
      if (i == 0) oe_mid = spi_miso_oe;
      if (i >= 16 && i < 32) rd[31-i] = spi_miso;
      else stray = stray | spi_miso;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk_clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk_clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
  endtask

  task automatic chk_bank(input string tag);
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s reg%0d", tag, k), {16'h0, regs_out[16*k +: 16]}, {16'h0, m[k]});
  endtask

  task automatic frame(input string tag, input logic rw, input logic [14:0] addr,
                       input logic [15:0] data, input int nbits, input int extra,
                       input int rst_bit);
    int          s0;
    logic [15:0] rd, exp_rd;
    logic        stray, hit, full;
    s0     = n_strobe;
    hit    = (addr < 15'd32);
    full   = (nbits >= 32) && (rst_bit < 0);
    exp_rd = (hit && full && !rw) ? m[addr[4:0]] : 16'h0;
    xfer({rw, addr, data}, nbits, extra, rst_bit, rd, stray);
    if (rst_bit >= 0) begin
      for (int k = 0; k < 32; k++) m[k] = 16'h0;
      exp_wa = '0;
    end
    if (full && rw && hit) begin
      m[addr[4:0]] = data;
      exp_wa       = addr[4:0];
    end
    chk({tag, " strobes"}, n_strobe - s0, (full && rw && hit) ? 1 : 0);
    chk({tag, " wr_addr"}, {27'h0, wr_addr}, {27'h0, exp_wa});
    chk({tag, " stray miso"}, {31'h0, stray}, 32'h0);
    if (full && !rw) chk({tag, " rd data"}, {16'h0, rd}, {16'h0, exp_rd});
    chk({tag, " oe idle"}, {31'h0, spi_miso_oe}, 32'h0);
    chk_bank(tag);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m[k] = 16'h0;
    repeat (5) @(negedge clk_clk);
    chk("rst miso", {31'h0, spi_miso}, 32'h0);
    chk("rst oe", {31'h0, spi_miso_oe}, 32'h0);
    chk("rst strobe", {31'h0, wr_strobe}, 32'h0);
    chk("rst wr_addr", {27'h0, wr_addr}, 32'h0);
    reset_reset = 1'b0;
    repeat (5) @(negedge clk_clk);
    chk_bank("rst");

    frame("rd3", 1'b0, 15'h0003, 16'h0, 32, 0, -1);
    chk("oe sel", {31'h0, oe_mid}, 32'h1);
    frame("wr2", 1'b1, 15'h0002, 16'hA5C3, 32, 0, -1);
    frame("rd2", 1'b0, 15'h0002, 16'h0, 32, 0, -1);
    frame("wr40", 1'b1, 15'h0040, 16'h1234, 32, 0, -1);
    frame("rd40", 1'b0, 15'h0040, 16'h0, 32, 0, -1);
    frame("abort", 1'b1, 15'h0001, 16'h7777, 20, 0, -1);
    frame("wr1", 1'b1, 15'h0001, 16'h00FF, 32, 0, -1);
    frame("wr1f", 1'b1, 15'h001F, 16'hBEEF, 32, 8, -1);
    frame("rd1f", 1'b0, 15'h001F, 16'h0, 32, 8, -1);
    frame("rstmid", 1'b1, 15'h0006, 16'h9999, 32, 0, 10);
    frame("wr4", 1'b1, 15'h0004, 16'h5555, 32, 0, -1);
    frame("rd4", 1'b0, 15'h0004, 16'h0, 32, 0, -1);

    for (int n = 0; n < 40; n++) begin
      int          r, nb, ex;
      logic [14:0] a;
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? $urandom_range(1, 31) : 32;
      ex = (r == 1) ? $urandom_range(1, 8) : 0;
      a  = (r == 2) ? 15'($urandom) : 15'($urandom_range(0, 63));
      frame($sformatf("rnd%0d", n), 1'($urandom), a, 16'($urandom), nb, ex, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpga_spi_regs.md
# fpga_spi_regs

SPI responder and 16-bit register file: the FPGA-side end of the control processor's `fpga_spi_ext` master link. It receives LMS7-style 32-bit frames (write flag, 15-bit address, 16-bit data), updates or returns a local bank of configuration registers, and presents the bank to the rest of the gateware. SCLK is oversampled in the system clock domain; no logic runs on SCLK.

## Interface
Parameters:
- `ADDR_W`, 5: register index width; bank holds 2^ADDR_W 16-bit registers.
- `BASE_ADDR`, 15'h0000: decoded block base; frame address matches when `addr[14:ADDR_W] == BASE_ADDR[14:ADDR_W]`.
- `RST_VAL`, 16'h0000: reset value of every register.

Ports:
- `clk_clk` in 1: system clock; the only clock. Must run at ≥8× SCLK.
- `reset_reset` in 1: synchronous, active-high reset.
- `spi_sclk` in 1: SPI clock, mode 0 (idle low), asynchronous to `clk_clk`.
- `spi_mosi` in 1: serial data in, MSB first.
- `spi_ss_n` in 1: active-low select (one bit of the master's `SS_n` bus).
- `spi_miso` out 1: serial data out.
- `spi_miso_oe` out 1: MISO drive enable; high only while selected.
- `regs_out` out 16·2^ADDR_W: flattened bank; register k at bits [16k+15:16k].
- `wr_strobe` out 1: one-cycle pulse on each committed write.
- `wr_addr` out ADDR_W: index of the last committed write.

## Operation
- Frame bits: b31 = 1 write / 0 read; b30..b16 = address; b15..b0 = data, MSB first.
- Input conditioning: `spi_sclk`, `spi_mosi`, `spi_ss_n` each pass through a 2-FF synchroniser plus one history register. An edge is detected on the 3rd-stage compare.
- States:
  - IDLE: `ss_n` high.
  - SHIFT: `ss_n` low, bit count < 32.
  - DONE: count = 32; later edges are ignored.
  - Falling edge of synced `ss_n` enters SHIFT and clears the 6-bit bit counter and the shift register.
  - Rising edge of `ss_n` returns to IDLE from any state.
- SHIFT:
  - On each detected SCLK rising edge, shift synced MOSI into the 32-bit shift-in register and increment the count.
  - On the 16th rising edge the address is complete. If the frame is a read, load the shift-out register with the addressed register, or 16'h0000 when the address misses BASE_ADDR.
  - On each SCLK falling edge after the 16th rising edge, `spi_miso` presents the next shift-out bit, starting with bit 15.
  - Outside bits 15..0 of a read frame, `spi_miso` = 0.
- Write commit:
  - Triggered on the 32nd rising edge, when b31 = 1 and the address hits.
  - The register updates in the cycle after detection; `wr_strobe` pulses in the same cycle and `wr_addr` updates.
  - A write to an address that misses is dropped, with no strobe.
- Abort: `ss_n` rising before the 32nd edge discards the frame. No write and no strobe occur, and the count clears.
- Bit counter saturates at 32; extra SCLKs in DONE do not wrap.
- `spi_miso_oe` = NOT synced `ss_n`.
- Reset:
  - All registers = RST_VAL; state IDLE; count 0.
  - `spi_miso` = 0, `spi_miso_oe` = 0, `wr_strobe` = 0, `wr_addr` = 0.
  - Reset mid-frame aborts the frame. The responder resynchronises only on the next `ss_n` falling edge, so a frame already in progress is ignored.

## Timing
- Pin-to-detect latency is 3 `clk_clk` cycles. The SCLK high and low phases must each be ≥4 cycles.
- The 32nd SCLK rising edge reaches `regs_out` and `wr_strobe` at cycle 4 after the pin edge.
- The read data load occurs at cycle 4 after the 16th rising edge, before the master's next falling edge. The 8× ratio guarantees this.
- `spi_miso` changes at cycle 4 after each SCLK falling edge at the pin and is stable before the next rising edge.
- `ss_n` high time between frames must be ≥4 cycles.
- A read and a write of the same register in successive frames return the new value.

## Test plan
- Reset, then read address 0x0003 → MISO returns 0x0000 and `regs_out` is all RST_VAL.
- Write 0xA5C3 to 0x0002, then read 0x0002 → exactly one `wr_strobe` with `wr_addr` = 2, register 2 = 0xA5C3, and the read shifts out 0xA5C3 on bits 15..0.
- Write 0x1234 to 0x0040 (out of range, BASE_ADDR = 0) → no strobe and bank unchanged. A read of 0x0040 returns 0x0000.
- Write frame with `ss_n` raised after 20 bits → no strobe and the register is unchanged. The next full write of 0x00FF to 0x0001 succeeds.
- Write 0xBEEF to 0x001F followed by 8 extra SCLKs → single strobe and register 31 = 0xBEEF. A following frame decodes correctly.
- Assert `reset_reset` during bit 10 of a write, release, then send a clean write of 0x5555 to 0x0004 → the partial frame is lost and register 4 = 0x5555. SCLK at exactly clk/8 throughout.
